event_log_writer: RTL and testbench

//  Parametrised successor to the single-cause reset logger. Takes N_SRC violation-cause pulses and snapshots
//  pc, bus address, enable and write per cause, with a timestamp. It serialises simultaneous causes into a
//  log RAM, one record per cycle. It sits between the VRASED monitors and the log RAM.

---
 rtl/event_log_writer_pkg.sv | 15 +
 rtl/event_log_writer_prio_enc.sv | 20 ++
 rtl/event_log_writer.sv | 163 ++++++++++++++++
 tb/tb_event_log_writer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/event_log_writer_pkg.sv
// Shared widths and helpers for the event log writer.
// Record layout, MSB first: {cid, pc, addr, en, wr, ts}.
package event_log_writer_pkg;
   localparam int PC_W      = 16;
   localparam int BUS_W     = 16;
   localparam int CID_EMPTY = 0;

   function automatic int cid_width(input int n_src);
      return $clog2(n_src + 1);
   endfunction

   function automatic int rec_width(input int n_src, input int ts_w);
      return cid_width(n_src) + PC_W + BUS_W + 2 + ts_w;
   endfunction
endpackage

// File: rtl/event_log_writer_prio_enc.sv
// Lowest-set-bit priority encoder; idx_o is only meaningful when valid_o is set.
module event_log_writer_prio_enc #(
   parameter int N = 6,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/event_log_writer.sv
// Snapshots violation causes into per-source slots and drains them into the log RAM,
// lowest source first, one record per cycle, with fill/wrap status and a drop counter.
module event_log_writer
   import event_log_writer_pkg::*;
#(
   parameter int               N_SRC    = 6,
   parameter logic [N_SRC-1:0] DMA_MASK = 6'h38,
   parameter int               ADDR_W   = 16,
   parameter int               DEPTH    = 65536,
   parameter int               WRAP     = 1,
   parameter int               TS_W     = 16,
   parameter int               DROP_W   = 8,
   localparam int              CID_W    = cid_width(N_SRC),
   localparam int              REC_W    = rec_width(N_SRC, TS_W)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              log_en_i,
   input  logic              clr_ram_i,
   input  logic [N_SRC-1:0]  src_evt_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [BUS_W-1:0]  data_addr_i,
   input  logic              data_en_i,
   input  logic              data_wr_i,
   input  logic [BUS_W-1:0]  dma_addr_i,
   input  logic              dma_en_i,
   output logic [REC_W-1:0]  wr_data_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic              we_o,
   output logic [ADDR_W:0]   log_cnt_o,
   output logic              log_full_o,
   output logic              log_wrapped_o,
   output logic [DROP_W-1:0] drop_cnt_o
);
   localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int SLOT_W = PC_W + BUS_W + 2 + TS_W;
   localparam int CNT_W  = ADDR_W + 1;
   localparam int NDW    = $clog2(2 * N_SRC + 1);
   localparam int SUM_W  = DROP_W + NDW;

   logic [TS_W-1:0]   ts_q;
   logic [N_SRC-1:0]  pend_q, pend_d;
   logic [SLOT_W-1:0] slot_q [N_SRC];
   logic [SLOT_W-1:0] slot_d [N_SRC];
   logic [REC_W-1:0]  wr_data_q, wr_data_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0]  log_cnt_q, log_cnt_d;
   logic              log_wrapped_q, log_wrapped_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic              sel_vld;
   logic [IDX_W-1:0]  sel_idx;
   logic              log_full;
   logic              open;
   logic [NDW-1:0]    n_drop;
   logic [SUM_W-1:0]  drop_sum;

   event_log_writer_prio_enc #(.N(N_SRC)) u_prio (
      .req_i   (pend_q),
      .valid_o (sel_vld),
      .idx_o   (sel_idx)
   );

   assign log_full = (log_cnt_q == CNT_W'(DEPTH));
   // A stopped, full log accepts nothing: new events and anything still queued are lost.
   assign open     = (WRAP != 0) || !log_full;

   always_comb begin
      pend_d        = pend_q;
      slot_d        = slot_q;
      wr_data_d     = '0;
      we_d          = 1'b0;
      wr_addr_d     = wr_addr_q;
      log_cnt_d     = log_cnt_q;
      log_wrapped_d = log_wrapped_q;
      n_drop        = '0;

      if (we_q) begin
         if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
            wr_addr_d = '0;
            if (WRAP != 0) log_wrapped_d = 1'b1;
         end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
         end
      end

      if (open) begin
         if (sel_vld) begin
            pend_d[sel_idx] = 1'b0;
            wr_data_d       = {CID_W'(sel_idx) + CID_W'(1), slot_q[sel_idx]};
            we_d            = 1'b1;
            if (!log_full) log_cnt_d = log_cnt_q + CNT_W'(1);
         end
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (pend_q[i]) begin
               pend_d[i] = 1'b0;
               n_drop    = n_drop + NDW'(1);
            end
         end
      end

      for (int i = 0; i < N_SRC; i++) begin
         if (log_en_i && src_evt_i[i]) begin
            if (!open) begin
               n_drop = n_drop + NDW'(1);
            end else if (!pend_q[i] || (sel_vld && sel_idx == IDX_W'(i))) begin
               pend_d[i] = 1'b1;
               slot_d[i] = DMA_MASK[i] ? {pc_i, dma_addr_i, dma_en_i, 1'b0, ts_q}
                                       : {pc_i, data_addr_i, data_en_i, data_wr_i, ts_q};
            end else begin
               n_drop = n_drop + NDW'(1);
            end
         end
      end

      drop_sum = SUM_W'(drop_q) + SUM_W'(n_drop);
      drop_d   = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}} : DROP_W'(drop_sum);

      if (clr_ram_i) begin
         pend_d        = '0;
         wr_data_d     = '0;
         we_d          = 1'b0;
         wr_addr_d     = '0;
         log_cnt_d     = '0;
         log_wrapped_d = 1'b0;
         drop_d        = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ts_q          <= '0;
         pend_q        <= '0;
         for (int i = 0; i < N_SRC; i++) slot_q[i] <= '0;
         wr_data_q     <= '0;
         we_q          <= 1'b0;
         wr_addr_q     <= '0;
         log_cnt_q     <= '0;
         log_wrapped_q <= 1'b0;
         drop_q        <= '0;
      end else begin
         ts_q          <= ts_q + TS_W'(1);
         pend_q        <= pend_d;
         slot_q        <= slot_d;
         wr_data_q     <= wr_data_d;
         we_q          <= we_d;
         wr_addr_q     <= wr_addr_d;
         log_cnt_q     <= log_cnt_d;
         log_wrapped_q <= log_wrapped_d;
         drop_q        <= drop_d;
      end
   end

   assign wr_data_o     = wr_data_q;
   assign wr_addr_o     = wr_addr_q;
   assign we_o          = we_q;
   assign log_cnt_o     = log_cnt_q;
   assign log_full_o    = log_full;
   assign log_wrapped_o = log_wrapped_q;
   assign drop_cnt_o    = drop_q;
endmodule

// File: tb/tb_event_log_writer.sv
// Scoreboard bench: a stop-mode and a wrap-mode writer (DEPTH=4) share most stimulus;
// expected records are queued at issue time and popped by a negedge monitor.
module tb_event_log_writer;
   localparam int RW = 53;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic log_en = 1'b0, clr = 1'b0;
   logic [5:0]  src_s = '0, src_w = '0;
   logic [15:0] pc = '0, daddr = '0, dma = '0;
   logic        den = 1'b0, dwr = 1'b0, dmaen = 1'b0;

   logic [RW-1:0] wd_s, wd_w;
   logic [1:0]    wa_s, wa_w;
   logic          we_s, we_w, full_s, full_w, wrp_s, wrp_w;
   logic [2:0]    cnt_s_o, cnt_w_o;
   logic [7:0]    drop_s, drop_w;

   int total = 0, bad = 0;
   logic [RW+1:0] q_s[$], q_w[$];
   logic [1:0]    addr_s = '0, addr_w = '0;
   int            cnt_s = 0;
   logic [15:0]   tb_ts;

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) tb_ts <= '0;
      else     tb_ts <= tb_ts + 16'd1;

   event_log_writer #(.N_SRC(6), .DMA_MASK(6'h38), .ADDR_W(2), .DEPTH(4), .WRAP(0),
                      .TS_W(16), .DROP_W(8)) u_stop (
      .clk_i(clk), .reset_i(rst), .log_en_i(log_en), .clr_ram_i(clr), .src_evt_i(src_s),
      .pc_i(pc), .data_addr_i(daddr), .data_en_i(den), .data_wr_i(dwr),
      .dma_addr_i(dma), .dma_en_i(dmaen),
      .wr_data_o(wd_s), .wr_addr_o(wa_s), .we_o(we_s), .log_cnt_o(cnt_s_o),
      .log_full_o(full_s), .log_wrapped_o(wrp_s), .drop_cnt_o(drop_s));

   event_log_writer #(.N_SRC(6), .DMA_MASK(6'h38), .ADDR_W(2), .DEPTH(4), .WRAP(1),
                      .TS_W(16), .DROP_W(8)) u_wrap (
      .clk_i(clk), .reset_i(rst), .log_en_i(log_en), .clr_ram_i(clr), .src_evt_i(src_w),
      .pc_i(pc), .data_addr_i(daddr), .data_en_i(den), .data_wr_i(dwr),
      .dma_addr_i(dma), .dma_en_i(dmaen),
      .wr_data_o(wd_w), .wr_addr_o(wa_w), .we_o(we_w), .log_cnt_o(cnt_w_o),
      .log_full_o(full_w), .log_wrapped_o(wrp_w), .drop_cnt_o(drop_w));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Expected record for source i from the bus values currently driven; sources 3..5 are DMA.
   function automatic logic [RW-1:0] mk_rec(input int i, input logic [15:0] ts);
      logic [2:0] cid;
      cid = 3'(i + 1);
      if (i >= 3) return {cid, pc, dma, dmaen, 1'b0, ts};
      else        return {cid, pc, daddr, den, dwr, ts};
   endfunction

   function automatic void push_s(input logic [RW-1:0] r);
      if (cnt_s < 4) begin
         q_s.push_back({r, addr_s});
         addr_s = addr_s + 2'd1;
         cnt_s++;
      end
   endfunction

   function automatic void push_w(input logic [RW-1:0] r);
      q_w.push_back({r, addr_w});
      addr_w = addr_w + 2'd1;
   endfunction

   function automatic void model_clear();
      addr_s = '0; addr_w = '0; cnt_s = 0;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (we_s) begin
            total++;
            if (q_s.size() == 0) begin
               bad++;
               $display("FAIL rec_stop unexpected got=%h/%0d want=none", wd_s, wa_s);
            end else begin
               logic [RW+1:0] e;
               e = q_s.pop_front();
               if ({wd_s, wa_s} !== e) begin
                  bad++;
                  $display("FAIL rec_stop got=%h/%0d want=%h/%0d", wd_s, wa_s, e[RW+1:2], e[1:0]);
               end
            end
         end else check("idle_data_stop", 64'(wd_s), 64'd0);
         if (we_w) begin
            total++;
            if (q_w.size() == 0) begin
               bad++;
               $display("FAIL rec_wrap unexpected got=%h/%0d want=none", wd_w, wa_w);
            end else begin
               logic [RW+1:0] e;
               e = q_w.pop_front();
               if ({wd_w, wa_w} !== e) begin
                  bad++;
                  $display("FAIL rec_wrap got=%h/%0d want=%h/%0d", wd_w, wa_w, e[RW+1:2], e[1:0]);
               end
            end
         end else check("idle_data_wrap", 64'(wd_w), 64'd0);
      end
   end

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      model_clear();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_we"},   64'({we_s, we_w}), 64'd0);
      check({tag, "_data"}, 64'({wd_s, wd_w}), 64'd0);
      check({tag, "_addr"}, 64'({wa_s, wa_w}), 64'd0);
      check({tag, "_cnt"},  64'({cnt_s_o, cnt_w_o}), 64'd0);
      check({tag, "_flag"}, 64'({full_s, full_w, wrp_s, wrp_w}), 64'd0);
      check({tag, "_drop"}, 64'({drop_s, drop_w}), 64'd0);
   endtask

   initial begin
      tick(2);
      check_zero("reset");
      rst = 1'b0;
      log_en = 1'b1;
      tick();

      // reset mid-stream with three causes pending
      src_s = 6'h07; src_w = 6'h07;
      tick();
      src_s = '0; src_w = '0;
      rst = 1'b1;
      #2;
      check_zero("reset_mid");
      tick();
      rst = 1'b0;
      model_clear();
      pc = 16'h0100; daddr = 16'h0010; den = 1'b1; dwr = 1'b0;
      src_s = 6'h01; src_w = 6'h01;
      push_s(mk_rec(0, tb_ts)); push_w(mk_rec(0, tb_ts));
      tick();
      src_s = '0; src_w = '0;
      tick(3);

      // single cause, address advances the cycle after the record
      do_clear();
      pc = 16'hE000; daddr = 16'h0200; den = 1'b1; dwr = 1'b1;
      src_s = 6'h01; src_w = 6'h01;
      push_s(mk_rec(0, tb_ts)); push_w(mk_rec(0, tb_ts));
      tick();
      src_s = '0; src_w = '0;
      tick(2);
      check("addr_after_one", 64'({wa_s, wa_w}), 64'({2'd1, 2'd1}));
      check("cnt_after_one",  64'({cnt_s_o, cnt_w_o}), 64'({3'd1, 3'd1}));

      // three simultaneous causes, two of them DMA-sourced
      do_clear();
      pc = 16'h1234; daddr = 16'h0AAA; den = 1'b1; dwr = 1'b0; dma = 16'h0BBB; dmaen = 1'b1;
      src_s = 6'h29; src_w = 6'h29;
      foreach (q_s[k]) ;
      push_s(mk_rec(0, tb_ts)); push_s(mk_rec(3, tb_ts)); push_s(mk_rec(5, tb_ts));
      push_w(mk_rec(0, tb_ts)); push_w(mk_rec(3, tb_ts)); push_w(mk_rec(5, tb_ts));
      tick();
      src_s = '0; src_w = '0;
      tick(4);
      check("cnt_after_three", 64'({cnt_s_o, cnt_w_o}), 64'({3'd3, 3'd3}));

      // re-pulse of a still-pending source is dropped; the original snapshot is logged
      do_clear();
      pc = 16'h2000; daddr = 16'h0300; den = 1'b1; dwr = 1'b0;
      src_s = 6'h05; src_w = 6'h05;
      push_s(mk_rec(0, tb_ts)); push_s(mk_rec(2, tb_ts));
      push_w(mk_rec(0, tb_ts)); push_w(mk_rec(2, tb_ts));
      tick();
      pc = 16'h3000; daddr = 16'h0400;
      src_s = 6'h04; src_w = 6'h04;
      tick();
      src_s = '0; src_w = '0;
      tick(3);
      check("drop_repulse", 64'({drop_s, drop_w}), 64'({8'd1, 8'd1}));

      // six single events into a 4-deep log, stop vs wrap
      do_clear();
      den = 1'b0; dwr = 1'b1;
      for (int k = 0; k < 6; k++) begin
         pc = 16'h4000 + 16'(k); daddr = 16'h0500 + 16'(k);
         src_s = 6'h01; src_w = 6'h01;
         push_s(mk_rec(0, tb_ts)); push_w(mk_rec(0, tb_ts));
         tick();
         src_s = '0; src_w = '0;
         tick();
      end
      tick(2);
      check("stop_full",    64'(full_s), 64'd1);
      check("stop_drop",    64'(drop_s), 64'd2);
      check("stop_cnt",     64'(cnt_s_o), 64'd4);
      check("stop_wrapped", 64'(wrp_s), 64'd0);
      check("wrap_wrapped", 64'(wrp_w), 64'd1);
      check("wrap_cnt",     64'(cnt_w_o), 64'd4);
      check("wrap_drop",    64'(drop_w), 64'd0);
      check("wrap_addr",    64'(wa_w), 64'd2);

      // saturate the stop-mode drop counter, then clear alongside a new event
      src_s = 6'h3F;
      tick(50);
      src_s = '0;
      check("drop_saturate", 64'(drop_s), 64'd255);
      clr = 1'b1; src_s = 6'h01; src_w = 6'h01;
      tick();
      clr = 1'b0; src_s = '0; src_w = '0;
      model_clear();
      check_zero("clr");
      tick(4);
      check("clr_no_record", 64'(cnt_s_o), 64'd0);

      check("queue_left_stop", 64'(q_s.size()), 64'd0);
      check("queue_left_wrap", 64'(q_w.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end
endmodule
